// File: rtl/trace_shadow_pipe.sv
// trace_shadow_pipe: shadow copy of the EX/MEM/WB pipe that assembles one
// retirement-aligned trace record per cycle for the CPU trace printer.
module trace_shadow_pipe #(
   parameter logic [31:0] CPUID = 32'd0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        issue_valid,
   input  logic [31:0] issue_instr,
   input  logic [31:0] issue_pc,
   input  logic [31:0] ex_next_pc,
   input  logic [31:0] ex_branch_addr,
   input  logic [31:0] ex_imm,
   input  logic [31:0] mem_dat_addr,
   input  logic [31:0] mem_store_dat,
   input  logic [31:0] wb_reg_dat,
   input  logic [4:0]  wb_wsel,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] cpuid,
   output logic        wb_enable,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] next_pc_val,
   output logic [31:0] branch_addr,
   output logic [31:0] imm,
   output logic [31:0] dat_addr,
   output logic [31:0] store_dat,
   output logic [31:0] reg_dat,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  wsel,
   output logic [4:0]  shamt,
   output logic [15:0] lui_pre_shift,
   output logic        halted,
   output logic [31:0] retired_count,
   output logic        seq_err,
   output logic [15:0] mismatch_count
);

   logic        r_s1_valid;
   logic [31:0] r_s1_instr;
   logic [31:0] r_s1_pc;

   logic        r_s2_valid;
   logic [31:0] r_s2_instr;
   logic [31:0] r_s2_pc;
   logic [31:0] r_s2_next_pc;
   logic [31:0] r_s2_branch_addr;
   logic [31:0] r_s2_imm;

   logic        r_s3_valid;
   logic [31:0] r_s3_instr;
   logic [31:0] r_s3_pc;
   logic [31:0] r_s3_next_pc;
   logic [31:0] r_s3_branch_addr;
   logic [31:0] r_s3_imm;
   logic [31:0] r_s3_dat_addr;
   logic [31:0] r_s3_store_dat;

   logic        r_halted;
   logic [31:0] r_retired_count;
   logic [31:0] r_last_npc;
   logic        r_have_last;
   logic        r_seq_err;
   logic [15:0] r_mismatch_count;

   logic        w_retire;
   logic        w_halt_op;
   logic        w_pc_break;

   // A stalled record sitting in S3 is only presented once the stall lifts.
   assign w_retire   = r_s3_valid & ~stall & ~r_halted;
   assign w_halt_op  = (r_s3_instr[31:26] == 6'h3F);
   assign w_pc_break = r_have_last & (r_s3_pc != r_last_npc);

   // S1: capture at issue; flush squashes both the incoming issue and S1.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s1_valid <= 1'b0;
         r_s1_instr <= 32'd0;
         r_s1_pc    <= 32'd0;
      end else if (stall) begin
         r_s1_valid <= r_s1_valid & ~flush;
      end else begin
         r_s1_valid <= issue_valid & ~flush;
         r_s1_instr <= issue_instr;
         r_s1_pc    <= issue_pc;
      end
   end

   // S2: record leaving S1 picks up the resolved EX values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s2_valid       <= 1'b0;
         r_s2_instr       <= 32'd0;
         r_s2_pc          <= 32'd0;
         r_s2_next_pc     <= 32'd0;
         r_s2_branch_addr <= 32'd0;
         r_s2_imm         <= 32'd0;
      end else if (!stall) begin
         r_s2_valid       <= r_s1_valid & ~flush;
         r_s2_instr       <= r_s1_instr;
         r_s2_pc          <= r_s1_pc;
         r_s2_next_pc     <= ex_next_pc;
         r_s2_branch_addr <= ex_branch_addr;
         r_s2_imm         <= ex_imm;
      end
   end

   // S3: record leaving S2 picks up the MEM values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s3_valid       <= 1'b0;
         r_s3_instr       <= 32'd0;
         r_s3_pc          <= 32'd0;
         r_s3_next_pc     <= 32'd0;
         r_s3_branch_addr <= 32'd0;
         r_s3_imm         <= 32'd0;
         r_s3_dat_addr    <= 32'd0;
         r_s3_store_dat   <= 32'd0;
      end else if (!stall) begin
         r_s3_valid       <= r_s2_valid;
         r_s3_instr       <= r_s2_instr;
         r_s3_pc          <= r_s2_pc;
         r_s3_next_pc     <= r_s2_next_pc;
         r_s3_branch_addr <= r_s2_branch_addr;
         r_s3_imm         <= r_s2_imm;
         r_s3_dat_addr    <= mem_dat_addr;
         r_s3_store_dat   <= mem_store_dat;
      end
   end

   // Retirement bookkeeping: halt latch, counters and PC continuity.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_halted         <= 1'b0;
         r_retired_count  <= 32'd0;
         r_last_npc       <= 32'd0;
         r_have_last      <= 1'b0;
         r_seq_err        <= 1'b0;
         r_mismatch_count <= 16'd0;
      end else begin
         r_seq_err <= w_retire & w_pc_break;
         if (w_retire) begin
            r_retired_count <= r_retired_count + 32'd1;
            r_last_npc      <= r_s3_next_pc;
            r_have_last     <= 1'b1;
            if (w_halt_op) begin
               r_halted <= 1'b1;
            end
            if (w_pc_break && (r_mismatch_count != 16'hFFFF)) begin
               r_mismatch_count <= r_mismatch_count + 16'd1;
            end
         end
      end
   end

   assign cpuid          = CPUID;
   assign wb_enable      = w_retire;
   assign instr          = r_s3_instr;
   assign pc             = r_s3_pc;
   assign next_pc_val    = r_s3_next_pc;
   assign branch_addr    = r_s3_branch_addr;
   assign imm            = r_s3_imm;
   assign dat_addr       = r_s3_dat_addr;
   assign store_dat      = r_s3_store_dat;
   assign reg_dat        = wb_reg_dat;
   assign wsel           = wb_wsel;
   assign opcode         = r_s3_instr[31:26];
   assign rs             = r_s3_instr[25:21];
   assign rt             = r_s3_instr[20:16];
   assign shamt          = r_s3_instr[10:6];
   assign funct          = r_s3_instr[5:0];
   assign lui_pre_shift  = r_s3_instr[15:0];
   assign halted         = r_halted;
   assign retired_count  = r_retired_count;
   assign seq_err        = r_seq_err;
   assign mismatch_count = r_mismatch_count;

endmodule

// File: tb/tb_trace_shadow_pipe.sv
// Self-checking bench for trace_shadow_pipe: directed scenarios plus a
// randomized run against an age-based reference model of the record flow.
module tb_trace_shadow_pipe;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        issue_valid, stall, flush;
   logic [31:0] issue_instr, issue_pc, ex_next_pc, ex_branch_addr, ex_imm;
   logic [31:0] mem_dat_addr, mem_store_dat, wb_reg_dat;
   logic [4:0]  wb_wsel;
   logic [31:0] cpuid, instr, pc, next_pc_val, branch_addr, imm, dat_addr, store_dat, reg_dat;
   logic        wb_enable, halted, seq_err;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, wsel, shamt;
   logic [15:0] lui_pre_shift, mismatch_count;
   logic [31:0] retired_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] instr, pc, npc, baddr, imm, daddr, sdat;
      int          age;   // number of advancing edges since capture
   } rec_t;

   trace_shadow_pipe #(.CPUID(32'd3)) dut (
      .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_instr(issue_instr),
      .issue_pc(issue_pc), .ex_next_pc(ex_next_pc), .ex_branch_addr(ex_branch_addr),
      .ex_imm(ex_imm), .mem_dat_addr(mem_dat_addr), .mem_store_dat(mem_store_dat),
      .wb_reg_dat(wb_reg_dat), .wb_wsel(wb_wsel), .stall(stall), .flush(flush),
      .cpuid(cpuid), .wb_enable(wb_enable), .instr(instr), .pc(pc),
      .next_pc_val(next_pc_val), .branch_addr(branch_addr), .imm(imm),
      .dat_addr(dat_addr), .store_dat(store_dat), .reg_dat(reg_dat),
      .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .wsel(wsel), .shamt(shamt),
      .lui_pre_shift(lui_pre_shift), .halted(halted), .retired_count(retired_count),
      .seq_err(seq_err), .mismatch_count(mismatch_count)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      issue_instr = 32'd0; issue_pc = 32'd0; ex_next_pc = 32'd0;
      ex_branch_addr = 32'd0; ex_imm = 32'd0; mem_dat_addr = 32'd0;
      mem_store_dat = 32'd0; wb_reg_dat = 32'd0; wb_wsel = 5'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
   endtask

   task automatic issue(input logic [31:0] p, input logic [31:0] w);
      issue_valid = 1'b1; issue_pc = p; issue_instr = w;
   endtask

   task automatic test_reset();
      idle_inputs();
      RST = 1'b1;
      step();
      #2;
      checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL reset_wb: got %0b expected 0", wb_enable); end
      checks++; if ({instr, pc, next_pc_val} !== 96'd0) begin failures++; $display("FAIL reset_fields: got %0h expected 0", {instr, pc, next_pc_val}); end
      checks++; if ({halted, seq_err, retired_count, mismatch_count} !== 50'd0) begin failures++; $display("FAIL reset_status: got %0h expected 0", {halted, seq_err, retired_count, mismatch_count}); end
      checks++; if (cpuid !== 32'd3) begin failures++; $display("FAIL reset_cpuid: got %0d expected 3", cpuid); end
      RST = 1'b0;
      #2;
      checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL reset_first_cycle_wb: got %0b expected 0", wb_enable); end
      step();
   endtask

   task automatic test_single_issue();
      do_reset();
      issue(32'h0, 32'h24010005);
      step();
      issue_valid = 1'b0; ex_next_pc = 32'h4;
      #2;
      checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL single_early1: got %0b expected 0", wb_enable); end
      step();
      ex_next_pc = 32'h0;
      #2;
      checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL single_early2: got %0b expected 0", wb_enable); end
      step();
      wb_reg_dat = 32'd5; wb_wsel = 5'd1;
      #2;
      checks++; if (wb_enable !== 1'b1) begin failures++; $display("FAIL single_wb: got %0b expected 1", wb_enable); end
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL single_pc: got %0h expected 0", pc); end
      checks++; if (opcode !== 6'h09) begin failures++; $display("FAIL single_opcode: got %0h expected 9", opcode); end
      checks++; if (rt !== 5'd1) begin failures++; $display("FAIL single_rt: got %0d expected 1", rt); end
      checks++; if (reg_dat !== 32'd5) begin failures++; $display("FAIL single_reg_dat: got %0d expected 5", reg_dat); end
      checks++; if (next_pc_val !== 32'h4) begin failures++; $display("FAIL single_npc: got %0h expected 4", next_pc_val); end
      step();
      #2;
      checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL single_once: got %0b expected 0", wb_enable); end
      checks++; if (retired_count !== 32'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", retired_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc [3];
      do_reset();
      issue(32'h0, 32'h24010005); step();
      issue(32'h4, 32'h24020006); ex_next_pc = 32'h4; step();
      issue(32'h8, 32'h24030007); ex_next_pc = 32'h8; step();
      issue_valid = 1'b0; stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #2;
         checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL b2b_stall_wb%0d: got %0b expected 0", i, wb_enable); end
         step();
      end
      stall = 1'b0; ex_next_pc = 32'hC;
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
      for (int i = 0; i < 3; i++) begin
         #2;
         checks++; if (wb_enable !== 1'b1 || pc !== exp_pc[i]) begin failures++; $display("FAIL b2b_retire%0d: got wb=%0b pc=%0h expected wb=1 pc=%0h", i, wb_enable, pc, exp_pc[i]); end
         checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL b2b_seq%0d: got %0b expected 0", i, seq_err); end
         step();
      end
      #2;
      checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL b2b_no_dup: got %0b expected 0", wb_enable); end
      checks++; if (retired_count !== 32'd3 || mismatch_count !== 16'd0 || seq_err !== 1'b0) begin failures++; $display("FAIL b2b_final: got cnt=%0d mis=%0d seq=%0b expected 3/0/0", retired_count, mismatch_count, seq_err); end
   endtask

   task automatic test_flush();
      do_reset();
      issue(32'h0, 32'h24010005); step();
      issue(32'h4, 32'h24020006); ex_next_pc = 32'h4; step();
      issue(32'h8, 32'h24030007); ex_next_pc = 32'h8; step();
      issue(32'hC, 32'h24040008); ex_next_pc = 32'hC; flush = 1'b1;
      #2;
      checks++; if (wb_enable !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL flush_pre: got wb=%0b pc=%0h expected wb=1 pc=0", wb_enable, pc); end
      step();
      idle_inputs();
      #2;
      checks++; if (wb_enable !== 1'b1 || pc !== 32'h4) begin failures++; $display("FAIL flush_s2_retires: got wb=%0b pc=%0h expected wb=1 pc=4", wb_enable, pc); end
      for (int i = 0; i < 3; i++) begin
         step();
         #2;
         checks++; if (wb_enable !== 1'b0) begin failures++; $display("FAIL flush_dropped%0d: got %0b expected 0 (pc=%0h)", i, wb_enable, pc); end
      end
      checks++; if (retired_count !== 32'd2) begin failures++; $display("FAIL flush_count: got %0d expected 2", retired_count); end
   endtask

   task automatic test_seq_err();
      do_reset();
      issue(32'h0, 32'h24010005); step();
      issue(32'h10, 32'h24020006); ex_next_pc = 32'h4; step();
      issue_valid = 1'b0; ex_next_pc = 32'h14; step();
      #2;
      checks++; if (wb_enable !== 1'b1 || pc !== 32'h0 || seq_err !== 1'b0) begin failures++; $display("FAIL seq_first: got wb=%0b pc=%0h seq=%0b expected 1/0/0", wb_enable, pc, seq_err); end
      step();
      #2;
      checks++; if (wb_enable !== 1'b1 || pc !== 32'h10 || seq_err !== 1'b0 || mismatch_count !== 16'd0) begin failures++; $display("FAIL seq_second: got wb=%0b pc=%0h seq=%0b mis=%0d expected 1/10/0/0", wb_enable, pc, seq_err, mismatch_count); end
      step();
      #2;
      checks++; if (seq_err !== 1'b1 || mismatch_count !== 16'd1) begin failures++; $display("FAIL seq_pulse: got seq=%0b mis=%0d expected 1/1", seq_err, mismatch_count); end
      step();
      #2;
      checks++; if (seq_err !== 1'b0 || mismatch_count !== 16'd1) begin failures++; $display("FAIL seq_once: got seq=%0b mis=%0d expected 0/1", seq_err, mismatch_count); end
   endtask

   task automatic test_halt();
      do_reset();
      issue(32'h0, 32'hFFFFFFFF); step();
      issue(32'h4, 32'h24010005); ex_next_pc = 32'h4; step();
      issue(32'h8, 32'h24020006); ex_next_pc = 32'h8; step();
      issue(32'hC, 32'h24030007); ex_next_pc = 32'hC;
      #2;
      checks++; if (wb_enable !== 1'b1 || opcode !== 6'h3F || halted !== 1'b0) begin failures++; $display("FAIL halt_retire: got wb=%0b op=%0h halted=%0b expected 1/3f/0", wb_enable, opcode, halted); end
      step();
      for (int i = 0; i < 6; i++) begin
         issue(32'h10 + 32'(i * 4), 32'h24040008); ex_next_pc = issue_pc;
         #2;
         checks++; if (wb_enable !== 1'b0 || halted !== 1'b1 || retired_count !== 32'd1) begin failures++; $display("FAIL halt_frozen%0d: got wb=%0b halted=%0b cnt=%0d expected 0/1/1", i, wb_enable, halted, retired_count); end
         step();
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      issue(32'h0, 32'h24010005); step();
      issue(32'h4, 32'h24020006); ex_next_pc = 32'h4; step();
      issue(32'h8, 32'h24030007); ex_next_pc = 32'h8; step();
      issue(32'hC, 32'h24040008); ex_next_pc = 32'hC; step();
      issue(32'h10, 32'h24050009); stall = 1'b1; flush = 1'b1; RST = 1'b1;
      step();
      RST = 1'b0;
      idle_inputs();
      #2;
      checks++; if (wb_enable !== 1'b0 || {instr, pc, next_pc_val, branch_addr, imm, dat_addr, store_dat} !== 224'd0) begin failures++; $display("FAIL rst_mid_fields: got wb=%0b pc=%0h instr=%0h expected all 0", wb_enable, pc, instr); end
      checks++; if ({halted, seq_err, retired_count, mismatch_count} !== 50'd0) begin failures++; $display("FAIL rst_mid_status: got cnt=%0d mis=%0d expected 0", retired_count, mismatch_count); end
      for (int i = 0; i < 4; i++) begin
         step();
         #2;
         checks++; if (wb_enable !== 1'b0 || retired_count !== 32'd0) begin failures++; $display("FAIL rst_mid_quiet%0d: got wb=%0b cnt=%0d expected 0/0", i, wb_enable, retired_count); end
      end
   endtask

   task automatic test_random();
      rec_t        q[$];
      rec_t        nq[$];
      rec_t        rec, r3;
      logic        found, exp_wb, m_halted, m_have, m_seq;
      logic [31:0] m_ret, m_last, next_pc, s1_pc;
      logic [15:0] m_mis;
      logic        have_s1;
      do_reset();
      q = {};
      m_halted = 1'b0; m_have = 1'b0; m_seq = 1'b0;
      m_ret = 32'd0; m_last = 32'd0; m_mis = 16'd0; next_pc = 32'h100;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         have_s1 = 1'b0; s1_pc = 32'd0;
         foreach (q[k]) if (q[k].age == 1) begin have_s1 = 1'b1; s1_pc = q[k].pc; end
         stall       = ($urandom_range(0, 4) == 0);
         flush       = ($urandom_range(0, 11) == 0);
         issue_valid = ($urandom_range(0, 9) < 7);
         issue_pc    = ($urandom_range(0, 19) == 0) ? ($urandom & 32'hFFFF_FFFC) : next_pc;
         issue_instr = $urandom;
         if (issue_instr[31:26] == 6'h3F) issue_instr[31] = 1'b0;
         if (cyc == 2600) begin
            issue_valid = 1'b1; stall = 1'b0; flush = 1'b0; issue_instr = 32'hFC00_1234;
         end
         ex_next_pc     = (have_s1 && $urandom_range(0, 19) != 0) ? s1_pc + 32'd4 : $urandom;
         ex_branch_addr = $urandom; ex_imm = $urandom;
         mem_dat_addr   = $urandom; mem_store_dat = $urandom;
         wb_reg_dat     = $urandom; wb_wsel = 5'($urandom);
         #2;
         found = 1'b0;
         foreach (q[k]) if (q[k].age == 3) begin found = 1'b1; r3 = q[k]; end
         exp_wb = found && !stall && !m_halted;
         checks++; if (wb_enable !== exp_wb) begin failures++; $display("FAIL rand_wb c%0d: got %0b expected %0b", cyc, wb_enable, exp_wb); end
         if (exp_wb) begin
            checks++; if ({instr, pc, next_pc_val, branch_addr, imm, dat_addr, store_dat} !== {r3.instr, r3.pc, r3.npc, r3.baddr, r3.imm, r3.daddr, r3.sdat}) begin
               failures++; $display("FAIL rand_record c%0d: got pc=%0h instr=%0h npc=%0h ba=%0h imm=%0h da=%0h sd=%0h expected pc=%0h instr=%0h npc=%0h ba=%0h imm=%0h da=%0h sd=%0h",
                  cyc, pc, instr, next_pc_val, branch_addr, imm, dat_addr, store_dat, r3.pc, r3.instr, r3.npc, r3.baddr, r3.imm, r3.daddr, r3.sdat);
            end
            checks++; if (opcode !== 6'(r3.instr >> 26) || rs !== 5'(r3.instr >> 21) || rt !== 5'(r3.instr >> 16) ||
                          shamt !== 5'(r3.instr >> 6) || funct !== 6'(r3.instr) || lui_pre_shift !== 16'(r3.instr)) begin
               failures++; $display("FAIL rand_decode c%0d: got op=%0h rs=%0d rt=%0d sh=%0d fn=%0h lui=%0h for instr %0h", cyc, opcode, rs, rt, shamt, funct, lui_pre_shift, r3.instr);
            end
         end
         checks++; if (reg_dat !== wb_reg_dat || wsel !== wb_wsel) begin failures++; $display("FAIL rand_passthru c%0d: got %0h/%0d expected %0h/%0d", cyc, reg_dat, wsel, wb_reg_dat, wb_wsel); end
         checks++; if (halted !== m_halted || retired_count !== m_ret) begin failures++; $display("FAIL rand_status c%0d: got halted=%0b cnt=%0d expected %0b/%0d", cyc, halted, retired_count, m_halted, m_ret); end
         checks++; if (seq_err !== m_seq || mismatch_count !== m_mis) begin failures++; $display("FAIL rand_seq c%0d: got seq=%0b mis=%0d expected %0b/%0d", cyc, seq_err, mismatch_count, m_seq, m_mis); end
         step();
         // reference model: retirement effects, then record ageing
         m_seq = 1'b0;
         if (exp_wb) begin
            if (m_have && r3.pc != m_last) begin
               m_seq = 1'b1;
               if (m_mis != 16'hFFFF) m_mis = m_mis + 16'd1;
            end
            m_last = r3.npc; m_have = 1'b1; m_ret = m_ret + 32'd1;
            if ((r3.instr >> 26) == 32'h3F) m_halted = 1'b1;
         end
         nq = {};
         foreach (q[k]) begin
            rec = q[k];
            if (stall) begin
               if (!(flush && rec.age == 1)) nq.push_back(rec);
            end else if (rec.age == 1) begin
               if (!flush) begin
                  rec.npc = ex_next_pc; rec.baddr = ex_branch_addr; rec.imm = ex_imm; rec.age = 2;
                  nq.push_back(rec);
               end
            end else if (rec.age == 2) begin
               rec.daddr = mem_dat_addr; rec.sdat = mem_store_dat; rec.age = 3;
               nq.push_back(rec);
            end
         end
         if (!stall && issue_valid && !flush) begin
            rec.instr = issue_instr; rec.pc = issue_pc; rec.npc = 32'd0; rec.baddr = 32'd0;
            rec.imm = 32'd0; rec.daddr = 32'd0; rec.sdat = 32'd0; rec.age = 1;
            nq.push_back(rec);
         end
         if (!stall && issue_valid) next_pc = issue_pc + 32'd4;
         q = nq;
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_issue();
      test_back_to_back();
      test_flush();
      test_seq_err();
      test_halt();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
